// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 serial command receiver with rdy/clr_rdy handshake and error flags
module uart_cmd_rx #(
    parameter int BAUD_DIV = 2604,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state_q;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    rx_data_q;
    logic          rdy_q, frm_err_q, ovr_err_q;
    logic          tick_d;

    always_comb begin
        tick_d = (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            if (!tick_d) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // A completing frame below overrides this clear in the same cycle.
            if (clr_rdy) begin
                rdy_q     <= 1'b0;
                ovr_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        cnt_q   <= HALF_LD;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick_d) begin
                        if (rx_s_q) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q     <= BAUD_LD;
                            bit_cnt_q <= '0;
                            state_q   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick_d) begin
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        cnt_q     <= BAUD_LD;
                        if (bit_cnt_q == 4'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick_d) begin
                        if (rx_s_q) begin
                            rx_data_q <= shift_q;
                            rdy_q     <= 1'b1;
                            frm_err_q <= 1'b0;
                            ovr_err_q <= clr_rdy ? 1'b0 : (ovr_err_q | rdy_q);
                            state_q   <= IDLE;
                        end else begin
                            frm_err_q <= 1'b1;
                            state_q   <= BRK;
                        end
                    end
                end
                BRK: begin
                    // Held-low line: wait for release before hunting for a start edge.
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;
    localparam int BD = 16;
    localparam int HD = BD / 2;
    localparam int LAT = 2 + HD + 9 * BD;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy, frm_err, ovr_err;

    int total = 0;
    int bad = 0;

    logic [7:0] m_data;
    logic       m_rdy, m_frm, m_ovr;

    uart_cmd_rx #(.BAUD_DIV(BD), .HALF_DIV(HD)) dut (
        .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       clr_before;
        logic       e_rdy;
        logic [7:0] e_data;
        logic       e_frm;
        logic       e_ovr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic e_rdy, input logic [7:0] e_data,
                             input logic e_frm, input logic e_ovr);
        check({name, ".rdy"}, int'(rdy), int'(e_rdy));
        check({name, ".rx_data"}, int'(rx_data), int'(e_data));
        check({name, ".frm_err"}, int'(frm_err), int'(e_frm));
        check({name, ".ovr_err"}, int'(ovr_err), int'(e_ovr));
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        @(negedge clk);
    endtask

    // Line-level frame generator: start, 8 data bits LSB first, stop; a bad stop is followed by a long break.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop_ok;
        repeat (BD) @(negedge clk);
        if (!stop_ok) begin
            repeat (3 * BD) @(negedge clk);
            RX = 1'b1;
            repeat (BD) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    // Transaction-level reference: what one frame (optionally preceded by clr_rdy) does to the outputs.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic clr);
        if (clr) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
        if (stop_ok) begin
            m_ovr  = m_ovr | m_rdy;
            m_rdy  = 1'b1;
            m_data = b;
            m_frm  = 1'b0;
        end else begin
            m_frm = 1'b1;
        end
    endtask

    initial begin
        int cnt;
        logic [7:0] b;
        logic ok, clr;

        vecs[0] = '{8'h47, 1'b1, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[1] = '{8'h46, 1'b0, 1'b1, 1'b0, 8'h47, 1'b1, 1'b0};
        vecs[2] = '{8'h53, 1'b1, 1'b0, 1'b1, 8'h53, 1'b0, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};

        rst = 1'b1;
        RX = 1'b1;
        clr_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].clr_before) begin
                pulse_clr();
                check(.name($sformatf("vec%0d.clr_rdy", i)), .act(int'(rdy)), .exp(0));
            end
            send_frame(vecs[i].data, vecs[i].stop_ok);
            check_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_data,
                      vecs[i].e_frm, vecs[i].e_ovr);
        end

        pulse_clr();
        check_all("clr_after_ovr", 1'b0, 8'h3C, 1'b0, 1'b0);

        // Short low glitch must abort in START without touching outputs.
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BD) @(negedge clk);
        check_all("glitch", 1'b0, 8'h3C, 1'b0, 1'b0);

        cnt = 0;
        fork
            send_frame(8'h53, 1'b1);
            begin
                while (!rdy && cnt < 400) begin
                    @(negedge clk);
                    cnt++;
                end
            end
        join
        total++;
        if (cnt < LAT - 4 || cnt > LAT + 4) begin
            bad++;
            $display("FAIL latency: got %0d clks, expected %0d +/- 4", cnt, LAT);
        end
        check_all("after_glitch", 1'b1, 8'h53, 1'b0, 1'b0);

        // clr_rdy lands on the stop-bit sample edge while rdy is already set.
        fork
            send_frame(8'h47, 1'b1);
            begin
                repeat (LAT) @(negedge clk);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
        join
        check_all("clr_at_done", 1'b1, 8'h47, 1'b0, 1'b0);

        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (BD * 5 + HD) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_all("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0);
            end
        join
        repeat (2 * BD) @(negedge clk);
        check_all("aborted_frame", 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h47, 1'b1);
        check_all("post_rst_frame", 1'b1, 8'h47, 1'b0, 1'b0);

        m_data = 8'h47;
        m_rdy = 1'b1;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            clr = $urandom_range(0, 1) == 1;
            if (clr) pulse_clr();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_frame(b, ok);
            model_frame(b, ok, clr);
            check_all($sformatf("rand%0d", i), m_rdy, m_data, m_frm, m_ovr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
